// File: rtl/ram_wb_arbiter.sv
// rtl/ram_wb_arbiter.sv - single-port RAM arbiter for sniffer capture and host bridge Wishbone masters
// Optional RAM_ARB_FAIR_EN selects round-robin; default is sniffer priority with a starvation guard.
module ram_wb_arbiter #(
   parameter int ADDR_W    = 14,
   parameter int MAX_BURST = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [31:0]       snf_addr_i,
   input  logic [31:0]       snf_data_i,
   input  logic [3:0]        snf_sel_i,
   input  logic              snf_we_i,
   input  logic              snf_stb_i,
   input  logic              snf_cyc_i,
   output logic              snf_stall_o,
   output logic              snf_ack_o,
   input  logic [31:0]       hst_addr_i,
   input  logic [31:0]       hst_data_i,
   input  logic [3:0]        hst_sel_i,
   input  logic              hst_we_i,
   input  logic              hst_stb_i,
   input  logic              hst_cyc_i,
   output logic              hst_stall_o,
   output logic              hst_ack_o,
   output logic [31:0]       hst_data_o,
   output logic              ram_en_o,
   output logic              ram_we_o,
   output logic [3:0]        ram_be_o,
   output logic [ADDR_W-1:0] ram_addr_o,
   output logic [31:0]       ram_data_o,
   input  logic [31:0]       ram_q_i
);

   typedef enum logic {GNT_SNF = 1'b0, GNT_HST = 1'b1} gnt_e;

   logic       req_s, req_h, gnt_s, gnt_h, tie_snf;
   gnt_e       last_gnt_q, last_gnt_d;
   logic [7:0] starve_cnt_q, starve_cnt_d;
   logic       snf_ack_q, hst_ack_q;
   logic       unused_addr_bits;

   assign req_s = snf_cyc_i & snf_stb_i;
   assign req_h = hst_cyc_i & hst_stb_i;

`ifdef RAM_ARB_FAIR_EN
   assign tie_snf      = (last_gnt_q == GNT_HST);
   assign starve_cnt_d = '0;
`else
   // Host waits at most MAX_BURST contended sniffer beats before it gets a slot.
   assign tie_snf = (starve_cnt_q != 8'(MAX_BURST));
   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (gnt_h || !req_h)
         starve_cnt_d = '0;
      else if (gnt_s)
         starve_cnt_d = starve_cnt_q + 8'd1;
   end
`endif

   always_comb begin
      gnt_s = 1'b0;
      gnt_h = 1'b0;
      if (!rst_i) begin
         if (req_s && req_h) begin
            gnt_s = tie_snf;
            gnt_h = !tie_snf;
         end else begin
            gnt_s = req_s;
            gnt_h = req_h;
         end
      end
   end

   always_comb begin
      last_gnt_d = last_gnt_q;
      if (gnt_s)
         last_gnt_d = GNT_SNF;
      else if (gnt_h)
         last_gnt_d = GNT_HST;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         last_gnt_q   <= GNT_HST;
         starve_cnt_q <= '0;
         snf_ack_q    <= 1'b0;
         hst_ack_q    <= 1'b0;
      end else begin
         last_gnt_q   <= last_gnt_d;
         starve_cnt_q <= starve_cnt_d;
         snf_ack_q    <= gnt_s;
         hst_ack_q    <= gnt_h;
      end
   end

   // An ack still pending when reset rises is hidden for the reset cycle as well.
   assign snf_ack_o   = snf_ack_q & ~rst_i;
   assign hst_ack_o   = hst_ack_q & ~rst_i;
   assign snf_stall_o = rst_i | (req_s & ~gnt_s);
   assign hst_stall_o = rst_i | (req_h & ~gnt_h);
   assign hst_data_o  = ram_q_i;

   assign ram_en_o   = gnt_s | gnt_h;
   assign ram_we_o   = gnt_s ? snf_we_i : (gnt_h & hst_we_i);
   assign ram_be_o   = gnt_s ? snf_sel_i : hst_sel_i;
   assign ram_addr_o = gnt_s ? snf_addr_i[ADDR_W+1:2] : hst_addr_i[ADDR_W+1:2];
   assign ram_data_o = gnt_s ? snf_data_i : hst_data_i;

   assign unused_addr_bits = ^{snf_addr_i[31:ADDR_W+2], snf_addr_i[1:0],
                               hst_addr_i[31:ADDR_W+2], hst_addr_i[1:0]};

endmodule

// File: tb/tb_ram_wb_arbiter.sv
// tb/tb_ram_wb_arbiter.sv - self-checking bench for ram_wb_arbiter with behavioural grant and RAM model
module tb_ram_wb_arbiter;
   localparam int ADDR_W    = 14;
   localparam int MAX_BURST = 4;
   localparam int WORDS     = 1 << ADDR_W;

   logic              clk_i = 1'b0;
   logic              rst_i;
   logic [31:0]       snf_addr_i, snf_data_i, hst_addr_i, hst_data_i;
   logic [3:0]        snf_sel_i, hst_sel_i;
   logic              snf_we_i, snf_stb_i, snf_cyc_i, hst_we_i, hst_stb_i, hst_cyc_i;
   logic              snf_stall_o, snf_ack_o, hst_stall_o, hst_ack_o;
   logic [31:0]       hst_data_o, ram_data_o, ram_q_i;
   logic              ram_en_o, ram_we_o;
   logic [3:0]        ram_be_o;
   logic [ADDR_W-1:0] ram_addr_o;

   always #5 clk_i = ~clk_i;

   ram_wb_arbiter #(.ADDR_W(ADDR_W), .MAX_BURST(MAX_BURST)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .snf_addr_i(snf_addr_i), .snf_data_i(snf_data_i), .snf_sel_i(snf_sel_i),
      .snf_we_i(snf_we_i), .snf_stb_i(snf_stb_i), .snf_cyc_i(snf_cyc_i),
      .snf_stall_o(snf_stall_o), .snf_ack_o(snf_ack_o),
      .hst_addr_i(hst_addr_i), .hst_data_i(hst_data_i), .hst_sel_i(hst_sel_i),
      .hst_we_i(hst_we_i), .hst_stb_i(hst_stb_i), .hst_cyc_i(hst_cyc_i),
      .hst_stall_o(hst_stall_o), .hst_ack_o(hst_ack_o), .hst_data_o(hst_data_o),
      .ram_en_o(ram_en_o), .ram_we_o(ram_we_o), .ram_be_o(ram_be_o),
      .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o), .ram_q_i(ram_q_i)
   );

   // Environment RAM driven by the DUT; ref_mem is the bench's own view of what should be stored.
   logic [31:0] ram_mem [WORDS];
   logic [31:0] ref_mem [WORDS];
   always @(posedge clk_i) begin
      if (ram_en_o) begin
         if (ram_we_o) begin
            for (int b = 0; b < 4; b++)
               if (ram_be_o[b]) ram_mem[ram_addr_o][8*b +: 8] <= ram_data_o[8*b +: 8];
         end else begin
            ram_q_i <= ram_mem[ram_addr_o];
         end
      end
   end

   int          checks = 0, errors = 0;
   int          streak;           // contended sniffer wins since host last served
   bit          last_hst;
   bit          m_ack_s, m_ack_h, m_rd_vld;
   logic [31:0] m_rd;
   bit          exp_stall_s, exp_stall_h;
   int          n_sack, n_hack;
   logic [15:0] gseq;
   logic        obs_hack;
   logic [31:0] obs_hdata;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_snf(input bit cyc, input bit stb, input bit we, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] sel);
      snf_cyc_i = cyc; snf_stb_i = stb; snf_we_i = we; snf_addr_i = a; snf_data_i = d; snf_sel_i = sel;
   endtask

   task automatic set_hst(input bit cyc, input bit stb, input bit we, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] sel);
      hst_cyc_i = cyc; hst_stb_i = stb; hst_we_i = we; hst_addr_i = a; hst_data_i = d; hst_sel_i = sel;
   endtask

   // One bus cycle: predict, check mid-cycle, advance the model at the clock edge.
   task automatic step();
      bit rs, rh, gs, gh, tie;
      logic [ADDR_W-1:0] a;
      rs = snf_cyc_i & snf_stb_i;
      rh = hst_cyc_i & hst_stb_i;
      gs = 0; gh = 0;
      if (!rst_i) begin
         if (rs && rh) begin
`ifdef RAM_ARB_FAIR_EN
            tie = last_hst;
`else
            tie = (streak < MAX_BURST);
`endif
            gs = tie; gh = !tie;
         end else begin
            gs = rs; gh = rh;
         end
      end
      exp_stall_s = rst_i | (rs & !gs);
      exp_stall_h = rst_i | (rh & !gh);
      a = gs ? snf_addr_i[ADDR_W+1:2] : hst_addr_i[ADDR_W+1:2];
      @(negedge clk_i);
      chk("snf_stall", snf_stall_o, exp_stall_s);
      chk("hst_stall", hst_stall_o, exp_stall_h);
      chk("ram_en", ram_en_o, gs | gh);
      chk("ram_we", ram_we_o, gs ? snf_we_i : (gh & hst_we_i));
      if (gs | gh) begin
         chk("ram_addr", ram_addr_o, a);
         if (gs ? snf_we_i : hst_we_i) begin
            chk("ram_be", ram_be_o, gs ? snf_sel_i : hst_sel_i);
            chk("ram_data", ram_data_o, gs ? snf_data_i : hst_data_i);
         end
      end
      chk("snf_ack", snf_ack_o, !rst_i && m_ack_s);
      chk("hst_ack", hst_ack_o, !rst_i && m_ack_h);
      if (!rst_i && m_ack_h && m_rd_vld) chk("hst_data", hst_data_o, m_rd);
      n_sack += int'(snf_ack_o);
      n_hack += int'(hst_ack_o);
      obs_hack = hst_ack_o;
      obs_hdata = hst_data_o;
      gseq = {gseq[14:0], rh & !hst_stall_o & !rst_i};
      @(posedge clk_i);
      if (rst_i) begin
         streak = 0; last_hst = 1; m_ack_s = 0; m_ack_h = 0; m_rd_vld = 0;
      end else begin
         m_ack_s = gs; m_ack_h = gh;
         m_rd_vld = gh & !hst_we_i;
         if (gh && !hst_we_i) m_rd = ref_mem[a];
         if ((gs && snf_we_i) || (gh && hst_we_i))
            for (int b = 0; b < 4; b++)
               if (gs ? snf_sel_i[b] : hst_sel_i[b])
                  ref_mem[a][8*b +: 8] = gs ? snf_data_i[8*b +: 8] : hst_data_i[8*b +: 8];
         if (gh || !rh) streak = 0;
         else if (gs) streak++;
         if (gs | gh) last_hst = gh;
      end
      #1;
   endtask

   initial begin
      bit hold_s, hold_h;
      for (int i = 0; i < WORDS; i++) begin ram_mem[i] = '0; ref_mem[i] = '0; end
      ram_mem[4] = 32'hDEADBEEF; ref_mem[4] = 32'hDEADBEEF;
      streak = 0; last_hst = 1; m_ack_s = 0; m_ack_h = 0; m_rd_vld = 0; m_rd = '0;
      n_sack = 0; n_hack = 0; gseq = '0;

      // Reset with both masters requesting
      rst_i = 1;
      set_snf(1, 1, 1, 32'h0, 32'hA0, 4'hF);
      set_hst(1, 1, 0, 32'h10, 32'h0, 4'hF);
      step(); step();
      chk("reset_acks", n_sack + n_hack, 0);
      rst_i = 0;
      step();
      chk("post_reset_snf_first", gseq[0], 1'b0);

      // Sniffer alone, back-to-back writes
      set_hst(0, 0, 0, 32'h10, 32'h0, 4'hF);
      set_snf(1, 1, 1, 32'h4, 32'hA1, 4'hF); step();
      set_snf(1, 1, 1, 32'h8, 32'hA2, 4'hF); step();
      set_snf(0, 0, 0, 32'h0, 32'h0, 4'h0); step();
      chk("snf_burst_acks", n_sack, 3);

      // Host read alone
      set_hst(1, 1, 0, 32'h10, 32'h0, 4'hF); step();
      set_hst(0, 0, 0, 32'h0, 32'h0, 4'h0); step();
      chk("host_read_ack", obs_hack, 1'b1);
      chk("host_read_data", obs_hdata, 32'hDEADBEEF);

      // Continuous contention
      n_sack = 0; n_hack = 0;
`ifdef RAM_ARB_FAIR_EN
      for (int i = 0; i < 6; i++) begin
         set_snf(1, 1, 1, 32'h100 + 4*i, 32'hB0 + i, 4'hF);
         set_hst(1, 1, 0, 32'h10, 32'h0, 4'hF);
         step();
      end
      chk("fair_seq", gseq[5:0], 6'b010101);
      set_snf(0, 0, 0, 0, 0, 0); set_hst(0, 0, 0, 0, 0, 0); step();
      chk("fair_snf_acks", n_sack, 3);
      chk("fair_hst_acks", n_hack, 3);
`else
      for (int i = 0; i < 10; i++) begin
         set_snf(1, 1, 1, 32'h100 + 4*i, 32'hB0 + i, 4'hF);
         set_hst(1, 1, 0, 32'h10, 32'h0, 4'hF);
         step();
      end
      chk("prio_seq", gseq[9:0], 10'b0000100001);
      set_snf(0, 0, 0, 0, 0, 0); set_hst(0, 0, 0, 0, 0, 0); step();
      chk("prio_snf_acks", n_sack, 8);
      chk("prio_hst_acks", n_hack, 2);
`endif

      // Reset in the cycle after a host grant
      set_snf(1, 1, 1, 32'h200, 32'hC0, 4'h3); set_hst(1, 1, 0, 32'h10, 0, 4'hF);
      step(); step(); step();
      set_snf(0, 0, 0, 0, 0, 0); step();
      rst_i = 1; set_snf(1, 1, 1, 32'h204, 32'hC1, 4'hF); step();
      chk("reset_drops_hst_ack", obs_hack, 1'b0);
      rst_i = 0;
      for (int i = 0; i < 5; i++) step();
`ifdef RAM_ARB_FAIR_EN
      chk("post_reset_seq", gseq[4:0], 5'b01010);
`else
      chk("post_reset_seq", gseq[4:0], 5'b00001);
`endif

      // Randomized traffic, masters hold stalled beats most of the time
      hold_s = 0; hold_h = 0;
      for (int c = 0; c < 3000; c++) begin
         rst_i = ($urandom_range(0, 149) == 0);
         if (!(hold_s && $urandom_range(0, 9) != 0))
            set_snf($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0,
                    $urandom & 32'hFFFF_00FF, $urandom, 4'($urandom));
         if (!(hold_h && $urandom_range(0, 9) != 0))
            set_hst($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 1) != 0,
                    $urandom & 32'hFFFF_00FF, $urandom, 4'($urandom));
         step();
         hold_s = exp_stall_s && !rst_i;
         hold_h = exp_stall_h && !rst_i;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
